mobius_stream_seq: RTL

Sequential, streaming counterpart of the combinational Möbius butterfly network. It receives an N-bit vector as W-bit words over a valid/ready input, holds it in an N-bit register and applies one butterfly stage per clock for LOG2_N cycles. It then streams the result out W bits per word over a valid/ready output. Over GF(2) the transform is an involution, so the same block converts ANF to truth table and truth table back to ANF. It sits at the receiving end of the expanded-vector path and trades latency for a single stage of XOR logic.

---
 rtl/mobius_stream_seq_if.sv | 25 ++
 rtl/mobius_stream_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mobius_stream_seq_if.sv
// Stream bundle for the sequential Mobius transform: one valid/ready
// channel into the block and one out of it.
// Element j of a word is vector index (word*W + j).
interface mobius_stream_seq_if #(
  parameter int W = 64
) ();
  logic         in_valid;
  logic         in_ready;
  logic [0:W-1] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:W-1] out_data;

  // Environment side: drives input words, consumes result words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Transform side: accepts input words, produces result words.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mobius_stream_seq.sv
// Sequential Mobius (subset-XOR) transform over GF(2).
// Loads an N-bit vector W bits at a time, applies one butterfly stage
// per clock for LOG2_N clocks, then streams the result W bits at a time.
// The transform is its own inverse, so it serves both ANF -> truth table
// and truth table -> ANF.
module mobius_stream_seq #(
  parameter int N      = 16384,
  parameter int LOG2_N = 14,
  parameter int W      = 64
) (
  input  logic               clk,
  input  logic               rst,
  mobius_stream_seq_if.slave bus,
  output logic               busy
);

  localparam int NW    = N / W;
  localparam int WC_W  = (NW > 1) ? $clog2(NW) : 1;
  localparam int ST_W  = (LOG2_N > 0) ? $clog2(LOG2_N + 1) : 1;
  localparam int IDX_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int WB    = $clog2(W);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(NW - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOG2_N - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WC_W-1:0]  wc_r;
  logic [WC_W-1:0]  wc_nxt_s;
  logic [ST_W-1:0]  stage_r;
  logic [ST_W-1:0]  stage_nxt_s;
  logic [0:N-1]     v_r;
  logic [0:N-1]     stage_v_s;
  logic [IDX_W-1:0] base_s;
  logic             load_en_s;
  logic             comp_en_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  // Bit offset of the word currently addressed by the word counter.
  always_comb begin
    base_s = IDX_W'(wc_r) << WB;
  end

  // One butterfly stage: with d = N >> (s+1), bit i takes v[i] ^ v[i-d]
  // when bit log2(d) of i is set; all other bits hold. Offsets are
  // constants per stage, so each bit is a small mux over stages.
  always_comb begin
    stage_v_s = v_r;
    for (int s = 0; s < LOG2_N; s++) begin
      if (int'(stage_r) == s) begin
        for (int i = 0; i < N; i++) begin
          if ((i & (N >> (s + 1))) != 0) begin
            stage_v_s[IDX_W'(i)] = v_r[IDX_W'(i)] ^ v_r[IDX_W'(i - (N >> (s + 1)))];
          end else begin
            stage_v_s[IDX_W'(i)] = v_r[IDX_W'(i)];
          end
        end
      end else begin
        // Stages other than the current one contribute nothing.
      end
    end
  end

  // Next-state, counter updates and handshake/status decode.
  always_comb begin
    state_nxt_s = state_r;
    wc_nxt_s    = wc_r;
    stage_nxt_s = stage_r;
    load_en_s   = 1'b0;
    comp_en_s   = 1'b0;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_LOAD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          load_en_s = 1'b1;
          if (wc_r == WC_LAST) begin
            state_nxt_s = ST_COMPUTE;
            wc_nxt_s    = {WC_W{1'b0}};
            stage_nxt_s = {ST_W{1'b0}};
          end else begin
            wc_nxt_s = wc_r + WC_W'(1);
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_COMPUTE: begin
        busy_s    = 1'b1;
        comp_en_s = 1'b1;
        if (stage_r == ST_LAST) begin
          state_nxt_s = ST_UNLOAD;
          stage_nxt_s = {ST_W{1'b0}};
          wc_nxt_s    = {WC_W{1'b0}};
        end else begin
          stage_nxt_s = stage_r + ST_W'(1);
        end
      end
      ST_UNLOAD: begin
        busy_s      = 1'b1;
        out_valid_s = 1'b1;
        if (bus.out_ready) begin
          if (wc_r == WC_LAST) begin
            state_nxt_s = ST_LOAD;
            wc_nxt_s    = {WC_W{1'b0}};
          end else begin
            wc_nxt_s = wc_r + WC_W'(1);
          end
        end else begin
          state_nxt_s = ST_UNLOAD;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
        wc_nxt_s    = {WC_W{1'b0}};
        stage_nxt_s = {ST_W{1'b0}};
      end
    endcase
  end

  // Outputs come from registered state only; reset forces them quiet in
  // the very cycle it is sampled, before the state has actually changed.
  always_comb begin
    bus.in_ready  = in_ready_s & ~rst;
    bus.out_valid = out_valid_s & ~rst;
    busy          = busy_s & ~rst;
    if (out_valid_s && !rst) begin
      bus.out_data = v_r[base_s +: W];
    end else begin
      bus.out_data = {W{1'b0}};
    end
  end

  // State and counter registers; reset aborts any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
      wc_r    <= {WC_W{1'b0}};
      stage_r <= {ST_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wc_r    <= wc_nxt_s;
      stage_r <= stage_nxt_s;
    end
  end

  // Vector register: word writes while loading, whole-vector stage
  // updates while computing. Not cleared, since every load rewrites it.
  always_ff @(posedge clk) begin
    if (load_en_s && !rst) begin
      v_r[base_s +: W] <= bus.in_data;
    end else if (comp_en_s && !rst) begin
      v_r <= stage_v_s;
    end
  end

endmodule
